// File: rtl/data_memory_banked.sv
// data_memory_banked: banked byte region, word region and GPIO behind one registered-read request port
//   Optional feature macro: DMEM_GPIO_READBACK_EN maps GPIO_ADDR = BYTE_DEPTH+WORD_DEPTH as a readable/writable GPIO register.
//   Ports: clk, rst (sync, active-high); req_i/we_i/addr_i/wd_i request; rd_o/rvalid_o registered read data and pulse;
//   gpio_o/gpio_en_o registered GPIO value and update pulse; err_o sticky out-of-range flag, err_clr_i clears it.
module data_memory_banked #(
  parameter int unsigned BYTE_DEPTH = 152100,
  parameter int unsigned WORD_DEPTH = 1536,
  parameter int unsigned BANK_DEPTH = 10000,
  parameter int unsigned GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wd_i,
  input  logic              err_clr_i,
  output logic [31:0]       rd_o,
  output logic              rvalid_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              gpio_en_o,
  output logic              err_o
);
  localparam int unsigned NBANK = (BYTE_DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int unsigned BW = NBANK > 1 ? $clog2(NBANK) : 1;
  localparam int unsigned OW = BANK_DEPTH > 1 ? $clog2(BANK_DEPTH) : 1;
  localparam int unsigned XW = WORD_DEPTH > 1 ? $clog2(WORD_DEPTH) : 1;
  localparam logic [31:0] WORD_BASE = 32'(BYTE_DEPTH);
  localparam logic [31:0] GPIO_ADDR = 32'(BYTE_DEPTH + WORD_DEPTH);
  logic [7:0] bank_mem [NBANK][BANK_DEPTH];
  logic [31:0] word_mem [WORD_DEPTH];
  logic in_byte, in_word, in_gpio, oor, acc, rd_acc, wr_acc, gpio_wr;
  logic [BW-1:0] bank;
  logic [OW-1:0] off;
  logic [XW-1:0] widx;
  logic [31:0] rd_q, rd_d;
  logic rvalid_q, rvalid_d, gpio_en_q, gpio_en_d, err_q, err_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  always_comb begin
    in_byte = addr_i < WORD_BASE;
    in_word = !in_byte && addr_i < GPIO_ADDR;
`ifdef DMEM_GPIO_READBACK_EN
    in_gpio = addr_i == GPIO_ADDR;
`else
    in_gpio = 1'b0;
`endif
    oor = !(in_byte || in_word || in_gpio);
    // a request coinciding with reset is dropped entirely
    acc = req_i && !rst;
    rd_acc = acc && !we_i;
    wr_acc = acc && we_i;
    gpio_wr = wr_acc && (in_byte || in_gpio);
    bank = BW'(addr_i / BANK_DEPTH);
    off = OW'(addr_i % BANK_DEPTH);
    widx = XW'(addr_i - WORD_BASE);
    rd_d = !rd_acc ? rd_q :
           in_byte ? {24'h0, bank_mem[bank][off]} :
           in_word ? word_mem[widx] :
           in_gpio ? 32'(gpio_q) : 32'h0;
    rvalid_d = rd_acc;
    gpio_d = gpio_wr ? wd_i[GPIO_W-1:0] : gpio_q;
    gpio_en_d = gpio_wr;
    // a new out-of-range access beats a concurrent clear
    err_d = (acc && oor) || (err_q && !err_clr_i);
  end
  always_ff @(posedge clk) begin
    if (wr_acc && in_byte) bank_mem[bank][off] <= wd_i[7:0];
    if (wr_acc && in_word) word_mem[widx] <= wd_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rvalid_q <= 1'b0;
      gpio_q <= '0;
      gpio_en_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      rvalid_q <= rvalid_d;
      gpio_q <= gpio_d;
      gpio_en_q <= gpio_en_d;
      err_q <= err_d;
    end
  end
  assign rd_o = rd_q;
  assign rvalid_o = rvalid_q;
  assign gpio_o = gpio_q;
  assign gpio_en_o = gpio_en_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked: directed and randomized checks of data_memory_banked against an address-map model
module tb_data_memory_banked;
  localparam logic [31:0] BD = 32'd152100;
  localparam logic [31:0] WD = 32'd1536;
  localparam logic [31:0] GA = BD + WD;
  logic clk = 1'b0, rst = 1'b0, req = 1'b0, we = 1'b0, err_clr = 1'b0;
  logic [31:0] addr = '0, wd = '0, rd;
  logic rvalid, gpio_en, err;
  logic [7:0] gpio;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_byte [logic [31:0]];
  logic [31:0] m_word [logic [31:0]];
  logic [31:0] e_rd = '0;
  logic e_rvalid = 1'b0, e_gpio_en = 1'b0, e_err = 1'b0;
  logic [7:0] e_gpio = '0;
  data_memory_banked dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wd_i(wd),
    .err_clr_i(err_clr), .rd_o(rd), .rvalid_o(rvalid), .gpio_o(gpio),
    .gpio_en_o(gpio_en), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic clr, input logic rs);
    logic ob, ow, og;
    req = r; we = w; addr = a; wd = d; err_clr = clr; rst = rs;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; err_clr = 1'b0; rst = 1'b0;
    ob = a < BD;
    ow = !ob && a < GA;
`ifdef DMEM_GPIO_READBACK_EN
    og = a == GA;
`else
    og = 1'b0;
`endif
    if (rs) begin
      e_rd = '0; e_rvalid = 1'b0; e_gpio = '0; e_gpio_en = 1'b0; e_err = 1'b0;
    end else begin
      e_rvalid = r && !w;
      e_gpio_en = r && w && (ob || og);
      if (r && !(ob || ow || og)) e_err = 1'b1;
      else if (clr) e_err = 1'b0;
      if (r && !w) e_rd = ob ? {24'h0, m_byte[a]} : ow ? m_word[a] : og ? {24'h0, e_gpio} : 32'h0;
      if (r && w && ob) m_byte[a] = d[7:0];
      if (r && w && ow) m_word[a] = d;
      if (e_gpio_en) e_gpio = d[7:0];
    end
  endtask
  task automatic test_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_cmp += 5;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_rd got %h want 0", rd); end
    if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    if (gpio !== 8'h0) begin n_bad++; $display("FAIL reset_gpio got %h want 0", gpio); end
    if (gpio_en !== 1'b0) begin n_bad++; $display("FAIL reset_gpio_en got %b want 0", gpio_en); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
  endtask
  task automatic test_bank_boundary();
    step(1'b1, 1'b1, 32'd9999, 32'hFFFF_FFA5, 1'b0, 1'b0);
    n_cmp += 3;
    if (gpio !== 8'hA5) begin n_bad++; $display("FAIL bb_gpio1 got %h want a5", gpio); end
    if (gpio_en !== 1'b1) begin n_bad++; $display("FAIL bb_gpio_en1 got %b want 1", gpio_en); end
    if (rvalid !== 1'b0) begin n_bad++; $display("FAIL bb_wr_rvalid got %b want 0", rvalid); end
    step(1'b1, 1'b1, 32'd10000, 32'h0000_003C, 1'b0, 1'b0);
    n_cmp += 2;
    if (gpio !== 8'h3C) begin n_bad++; $display("FAIL bb_gpio2 got %h want 3c", gpio); end
    if (gpio_en !== 1'b1) begin n_bad++; $display("FAIL bb_gpio_en2 got %b want 1", gpio_en); end
    step(1'b1, 1'b0, 32'd9999, 32'h0, 1'b0, 1'b0);
    n_cmp += 3;
    if (rd !== 32'h0000_00A5) begin n_bad++; $display("FAIL bb_rd9999 got %h want 000000a5", rd); end
    if (rvalid !== 1'b1) begin n_bad++; $display("FAIL bb_rvalid9999 got %b want 1", rvalid); end
    if (gpio_en !== 1'b0) begin n_bad++; $display("FAIL bb_rd_gpio_en got %b want 0", gpio_en); end
    step(1'b1, 1'b0, 32'd10000, 32'h0, 1'b0, 1'b0);
    n_cmp += 2;
    if (rd !== 32'h0000_003C) begin n_bad++; $display("FAIL bb_rd10000 got %h want 0000003c", rd); end
    if (rvalid !== 1'b1) begin n_bad++; $display("FAIL bb_rvalid10000 got %b want 1", rvalid); end
    step(1'b0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
    n_cmp += 2;
    if (rvalid !== 1'b0) begin n_bad++; $display("FAIL bb_idle_rvalid got %b want 0", rvalid); end
    if (rd !== 32'h0000_003C) begin n_bad++; $display("FAIL bb_rd_hold got %h want 0000003c", rd); end
    step(1'b1, 1'b1, BD - 1, 32'h0000_0077, 1'b0, 1'b0);
    step(1'b1, 1'b0, BD - 1, 32'h0, 1'b0, 1'b0);
    n_cmp++;
    if (rd !== 32'h0000_0077) begin n_bad++; $display("FAIL bb_last_byte got %h want 00000077", rd); end
  endtask
  task automatic test_word_region();
    step(1'b1, 1'b1, BD, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_cmp += 2;
    if (gpio_en !== 1'b0) begin n_bad++; $display("FAIL wr_gpio_en got %b want 0", gpio_en); end
    if (gpio !== 8'h77) begin n_bad++; $display("FAIL wr_gpio_keep got %h want 77", gpio); end
    step(1'b1, 1'b0, BD, 32'h0, 1'b0, 1'b0);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rd_first got %h want deadbeef", rd); end
    step(1'b1, 1'b1, GA - 1, 32'h0000_1234, 1'b0, 1'b0);
    step(1'b1, 1'b0, GA - 1, 32'h0, 1'b0, 1'b0);
    n_cmp += 2;
    if (rd !== 32'h0000_1234) begin n_bad++; $display("FAIL wr_rd_last got %h want 00001234", rd); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b want 0", err); end
  endtask
  task automatic test_out_of_range();
    logic [31:0] oa;
`ifdef DMEM_GPIO_READBACK_EN
    oa = GA + 1;
`else
    oa = GA;
`endif
    step(1'b1, 1'b0, oa, 32'h0, 1'b0, 1'b0);
    n_cmp += 3;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd got %h want 0", rd); end
    if (rvalid !== 1'b1) begin n_bad++; $display("FAIL oor_rvalid got %b want 1", rvalid); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err_set got %b want 1", err); end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL oor_err_clr got %b want 0", err); end
    step(1'b1, 1'b1, oa, 32'h5555_5555, 1'b1, 1'b0);
    n_cmp += 3;
    if (err !== 1'b1) begin n_bad++; $display("FAIL oor_set_wins got %b want 1", err); end
    if (gpio_en !== 1'b0) begin n_bad++; $display("FAIL oor_gpio_en got %b want 0", gpio_en); end
    if (gpio !== 8'h77) begin n_bad++; $display("FAIL oor_gpio_keep got %h want 77", gpio); end
    step(1'b1, 1'b0, GA - 1, 32'h0, 1'b1, 1'b0);
    n_cmp += 2;
    if (rd !== 32'h0000_1234) begin n_bad++; $display("FAIL oor_no_write got %h want 00001234", rd); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL oor_clr2 got %b want 0", err); end
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    n_cmp += 2;
    if (err !== 1'b1) begin n_bad++; $display("FAIL oor_top_err got %b want 1", err); end
    if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_top_rd got %h want 0", rd); end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask
  task automatic test_back_to_back();
    logic [7:0] v [3];
    for (int i = 0; i < 3; i++) begin
      v[i] = 8'($urandom);
      step(1'b1, 1'b1, 32'(i), {24'h0, v[i]}, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'(i), 32'h0, 1'b0, 1'b0);
      n_cmp += 2;
      if (rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid%0d got %b want 1", i, rvalid); end
      if (rd !== {24'h0, v[i]}) begin n_bad++; $display("FAIL b2b_rd%0d got %h want %h", i, rd, {24'h0, v[i]}); end
    end
    step(1'b1, 1'b1, 32'd5, 32'h0000_0011, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd5, 32'h0000_0099, 1'b0, 1'b1);
    n_cmp += 2;
    if (gpio !== 8'h0) begin n_bad++; $display("FAIL rstwr_gpio got %h want 0", gpio); end
    if (gpio_en !== 1'b0) begin n_bad++; $display("FAIL rstwr_gpio_en got %b want 0", gpio_en); end
    step(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 1'b0);
    n_cmp++;
    if (rd !== 32'h0000_0011) begin n_bad++; $display("FAIL rstwr_old got %h want 00000011", rd); end
  endtask
`ifdef DMEM_GPIO_READBACK_EN
  task automatic test_gpio_readback();
    step(1'b1, 1'b1, GA, 32'h0000_0081, 1'b0, 1'b0);
    n_cmp += 2;
    if (gpio !== 8'h81) begin n_bad++; $display("FAIL gr_gpio got %h want 81", gpio); end
    if (gpio_en !== 1'b1) begin n_bad++; $display("FAIL gr_gpio_en got %b want 1", gpio_en); end
    step(1'b1, 1'b0, GA, 32'h0, 1'b0, 1'b0);
    n_cmp += 3;
    if (rd !== 32'h0000_0081) begin n_bad++; $display("FAIL gr_rd got %h want 00000081", rd); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL gr_err got %b want 0", err); end
    if (rvalid !== 1'b1) begin n_bad++; $display("FAIL gr_rvalid got %b want 1", rvalid); end
  endtask
`endif
  task automatic test_random();
    logic [31:0] pool [18];
    logic [31:0] a;
    logic r, w, c, s;
    pool = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd9999, 32'd10000, 32'd19999, 32'd20000,
             32'd149999, 32'd150000, BD - 2, BD - 1, BD, BD + 1, GA - 1, GA, GA + 1, 32'h8000_0000};
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, pool[i], $urandom, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int n = 0; n < 400; n++) begin
      a = pool[$urandom_range(0, 17)];
      r = $urandom_range(0, 7) != 0;
      w = 1'($urandom);
      c = $urandom_range(0, 5) == 0;
      s = $urandom_range(0, 40) == 0;
      step(r, w, a, $urandom, c, s);
      n_cmp += 5;
      if (rd !== e_rd) begin n_bad++; $display("FAIL rnd_rd n=%0d addr=%0d got %h want %h", n, a, rd, e_rd); end
      if (rvalid !== e_rvalid) begin n_bad++; $display("FAIL rnd_rvalid n=%0d got %b want %b", n, rvalid, e_rvalid); end
      if (gpio !== e_gpio) begin n_bad++; $display("FAIL rnd_gpio n=%0d got %h want %h", n, gpio, e_gpio); end
      if (gpio_en !== e_gpio_en) begin n_bad++; $display("FAIL rnd_gpio_en n=%0d got %b want %b", n, gpio_en, e_gpio_en); end
      if (err !== e_err) begin n_bad++; $display("FAIL rnd_err n=%0d got %b want %b", n, err, e_err); end
    end
  endtask
  initial begin
    test_reset();
    test_bank_boundary();
    test_word_region();
    test_out_of_range();
    test_back_to_back();
`ifdef DMEM_GPIO_READBACK_EN
    test_gpio_readback();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
